// File: rtl/jpc_pkg.sv
// Shared fetch-unit definitions. ST_HALT exists only when JPC_IFETCH_FAULT_EN is defined.
package jpc_pkg;
    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
`ifdef JPC_IFETCH_FAULT_EN
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
`else
        ST_STALL = 2'd1
`endif
    } fetch_state_t;
endpackage

// File: rtl/jpc_ifetch_fifo.sv
// Instruction/address buffer for the fetch unit: push, pop, flush, full/empty/count.
module jpc_ifetch_fifo
    import jpc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [XLEN-1:0]            push_data,
    input  logic [XLEN-1:0]            push_addr,
    input  logic                       pop,
    input  logic                       flush,
    output logic [XLEN-1:0]            head_data,
    output logic [XLEN-1:0]            head_addr,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] addr_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_pop;
    logic            do_push;

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && !flush && ((cnt != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            cnt    <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_data;
            addr_mem[wr_ptr] <= push_addr;
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
endmodule

// File: rtl/jpc_ifetch.sv
// Fetch front end: credit-limited request issue, in-order response capture, redirect flush.
// Optional fetch-fault halt is compiled in only when JPC_IFETCH_FAULT_EN is defined.
module jpc_ifetch
    import jpc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_I,
    output logic [XLEN-1:0] next_pc_O,
    output logic            pc_enable_O,
    output logic            imem_req_valid_O,
    input  logic            imem_req_ready_I,
    output logic [XLEN-1:0] imem_req_addr_O,
    input  logic            imem_rsp_valid_I,
    input  logic [XLEN-1:0] imem_rsp_data_I,
`ifdef JPC_IFETCH_FAULT_EN
    input  logic            imem_rsp_err_I,
    output logic            fault_O,
    output logic [XLEN-1:0] fault_pc_O,
`endif
    output logic            inst_valid_O,
    input  logic            inst_ready_I,
    output logic [XLEN-1:0] inst_O,
    output logic [XLEN-1:0] inst_pc_O,
    input  logic            redirect_I,
    input  logic [XLEN-1:0] redirect_pc_I
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = CW + 1;

    fetch_state_t    state, state_n;
    logic [CW-1:0]   out_cnt, out_cnt_n;
    logic [CW-1:0]   stale_cnt, stale_cnt_n;
    logic [CW-1:0]   fifo_cnt, fifo_cnt_n;
    logic [OW-1:0]   occ, occ_n;
    logic [XLEN-1:0] aq_mem [DEPTH];
    logic [PW-1:0]   aq_wr, aq_wr_n, aq_rd, aq_rd_n;
    logic            redirect, redir_p1;
    logic            credit, credit_n;
    logic            req_valid, req_hs;
    logic            rsp_acc, rsp_live, rsp_err, stage_n;
    logic            rsp_vld_p1;
    logic [XLEN-1:0] rsp_data_p1, rsp_addr_p1;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    logic [XLEN-1:0] head_data, head_addr;

    assign redirect  = redirect_I && !rst;
    // The staged response still holds a slot, so it counts against credit.
    assign occ       = {1'b0, out_cnt} + {1'b0, fifo_cnt} + OW'(rsp_vld_p1);
    assign credit    = (occ < OW'(DEPTH));
    assign req_valid = !rst && !redirect && (state == ST_FETCH) && credit;
    assign req_hs    = req_valid && imem_req_ready_I;

    assign rsp_acc  = imem_rsp_valid_I && (out_cnt != '0);
    assign rsp_live = rsp_acc && (stale_cnt == '0) && !redirect;
`ifdef JPC_IFETCH_FAULT_EN
    assign rsp_err  = rsp_live && imem_rsp_err_I;
`else
    assign rsp_err  = 1'b0;
`endif
    assign stage_n  = rsp_live && !rsp_err;

    assign inst_valid_O = !rst && !fifo_empty && !redirect && !redir_p1;
    assign pop          = inst_valid_O && inst_ready_I;
    assign push         = rsp_vld_p1 && !redirect && (!fifo_full || pop);

    assign out_cnt_n  = out_cnt + CW'(req_hs) - CW'(rsp_acc);
    assign fifo_cnt_n = redirect ? '0 : (fifo_cnt + CW'(push) - CW'(pop));
    assign occ_n      = {1'b0, out_cnt_n} + {1'b0, fifo_cnt_n} + OW'(stage_n);
    assign credit_n   = (occ_n < OW'(DEPTH));

    assign aq_wr_n = aq_wr + PW'(req_hs);
    assign aq_rd_n = (redirect || rsp_err) ? aq_wr_n : (aq_rd + PW'(rsp_live));

    // Everything still in flight after a redirect or fault belongs to the abandoned stream.
    always_comb begin
        if (redirect || rsp_err)
            stale_cnt_n = out_cnt_n;
        else if (rsp_acc && (stale_cnt != '0))
            stale_cnt_n = stale_cnt - CW'(1);
        else
            stale_cnt_n = stale_cnt;
    end

    always_comb begin
        state_n = credit_n ? ST_FETCH : ST_STALL;
`ifdef JPC_IFETCH_FAULT_EN
        if ((state == ST_HALT) || rsp_err)
            state_n = ST_HALT;
`endif
        if (redirect)
            state_n = ST_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            out_cnt    <= '0;
            stale_cnt  <= '0;
            redir_p1   <= 1'b0;
            rsp_vld_p1 <= 1'b0;
            aq_wr      <= '0;
            aq_rd      <= '0;
        end else begin
            state      <= state_n;
            out_cnt    <= out_cnt_n;
            stale_cnt  <= stale_cnt_n;
            redir_p1   <= redirect;
            rsp_vld_p1 <= stage_n;
            aq_wr      <= aq_wr_n;
            aq_rd      <= aq_rd_n;
        end
    end

    // p1: response paired with its request address, written to the buffer next cycle
    always_ff @(posedge clk) begin
        if (req_hs)
            aq_mem[aq_wr] <= pc_I;
        if (rsp_live) begin
            rsp_data_p1 <= imem_rsp_data_I;
            rsp_addr_p1 <= aq_mem[aq_rd];
        end
    end

`ifdef JPC_IFETCH_FAULT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_O    <= 1'b0;
            fault_pc_O <= '0;
        end else if (redirect) begin
            fault_O    <= 1'b0;
        end else if (rsp_err) begin
            fault_O    <= 1'b1;
            fault_pc_O <= aq_mem[aq_rd];
        end
    end
`endif

    jpc_ifetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rsp_data_p1),
        .push_addr (rsp_addr_p1),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head_data),
        .head_addr (head_addr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign imem_req_valid_O = req_valid;
    assign imem_req_addr_O  = pc_I;
    assign pc_enable_O      = req_hs || redirect;
    assign next_pc_O        = redirect ? redirect_pc_I :
                              (req_hs ? (pc_I + XLEN'(INSN_BYTES)) : '0);
    assign inst_O           = inst_valid_O ? head_data : '0;
    assign inst_pc_O        = inst_valid_O ? head_addr : '0;
endmodule

// File: tb/tb_jpc_ifetch.sv
// Directed bench for jpc_ifetch: PC register and instruction memory models around the DUT.
module tb_jpc_ifetch;
    import jpc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc, next_pc, req_addr, rsp_data, inst, inst_pc, redirect_pc;
    logic        pc_en, req_valid, req_ready, rsp_valid, rsp_err;
    logic        inst_valid, inst_ready, redirect;
    logic        mem_hold, spurious, err_en;
    logic [31:0] err_addr;
`ifdef JPC_IFETCH_FAULT_EN
    logic        fault;
    logic [31:0] fault_pc;
`endif

    logic        f_rst, f_push, f_pop, f_flush, f_full, f_empty;
    logic [31:0] f_wd, f_wa, f_hd, f_ha;
    logic [1:0]  f_cnt;

    int tests = 0;
    int fails = 0;
    int nreq  = 0;
    int pe_bad = 0;
    logic [31:0] log_pc[$];
    logic [31:0] log_data[$];
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    jpc_ifetch #(.DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_I             (pc),
        .next_pc_O        (next_pc),
        .pc_enable_O      (pc_en),
        .imem_req_valid_O (req_valid),
        .imem_req_ready_I (req_ready),
        .imem_req_addr_O  (req_addr),
        .imem_rsp_valid_I (rsp_valid),
        .imem_rsp_data_I  (rsp_data),
`ifdef JPC_IFETCH_FAULT_EN
        .imem_rsp_err_I   (rsp_err),
        .fault_O          (fault),
        .fault_pc_O       (fault_pc),
`endif
        .inst_valid_O     (inst_valid),
        .inst_ready_I     (inst_ready),
        .inst_O           (inst),
        .inst_pc_O        (inst_pc),
        .redirect_I       (redirect),
        .redirect_pc_I    (redirect_pc)
    );

    jpc_ifetch_fifo #(.DEPTH(2)) u_fifo (
        .clk       (clk),
        .rst       (f_rst),
        .push      (f_push),
        .push_data (f_wd),
        .push_addr (f_wa),
        .pop       (f_pop),
        .flush     (f_flush),
        .head_data (f_hd),
        .head_addr (f_ha),
        .full      (f_full),
        .empty     (f_empty),
        .count     (f_cnt)
    );

    // PC register
    always @(posedge clk or posedge rst) begin
        if (rst)        pc <= 32'h0;
        else if (pc_en) pc <= next_pc;
    end

    // Memory: responds in order, one cycle after the request, unless held
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
            mq.delete();
        end else begin
            if (req_valid && req_ready) mq.push_back(req_addr);
            if (spurious) begin
                rsp_valid <= 1'b1;
                rsp_data  <= 32'hDEADBEEF;
                rsp_err   <= 1'b0;
            end else if (!mem_hold && mq.size() != 0) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mq[0] ^ 32'hA5A5A5A5;
                rsp_err   <= err_en && (mq[0] == err_addr);
                void'(mq.pop_front());
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) nreq <= nreq + 1;
            if (pc_en !== ((req_valid && req_ready) || redirect)) pe_bad <= pe_bad + 1;
            if (inst_valid && inst_ready) begin
                log_pc.push_back(inst_pc);
                log_data.push_back(inst);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lp(input int i);
        return (i < log_pc.size()) ? log_pc[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] ld(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hxxxxxxxx;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mem_hold = 1'b0; spurious = 1'b0; err_en = 1'b0; err_addr = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n0, n1;
        f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_flush = 1'b0; f_wd = 32'h0; f_wa = 32'h0;
        do_reset();
        rst = 1'b1;

        // Reset values, with a redirect held during reset
        redirect = 1'b1; redirect_pc = 32'h55;
        neg();
        chk("rst_pc_enable", {31'b0, pc_en}, 32'h0);
        chk("rst_next_pc", next_pc, 32'h0);
        chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        redirect = 1'b0; redirect_pc = 32'h0;

        // Buffer: push and pop together while full
        tick(); f_rst = 1'b0;
        f_push = 1'b1; f_wd = 32'h11; f_wa = 32'h1;
        tick(); f_wd = 32'h22; f_wa = 32'h2;
        tick(); f_push = 1'b0;
        neg();
        chk("fifo_full", {31'b0, f_full}, 32'h1);
        chk("fifo_head_a", f_hd, 32'h11);
        tick(); f_push = 1'b1; f_pop = 1'b1; f_wd = 32'h33; f_wa = 32'h3;
        tick(); f_push = 1'b0; f_pop = 1'b0;
        neg();
        chk("fifo_cnt_pushpop", {30'b0, f_cnt}, 32'h2);
        chk("fifo_head_b_data", f_hd, 32'h22);
        chk("fifo_head_b_addr", f_ha, 32'h2);
        tick(); f_pop = 1'b1;
        tick(); f_pop = 1'b0;
        neg();
        chk("fifo_head_c_data", f_hd, 32'h33);
        chk("fifo_head_c_addr", f_ha, 32'h3);
        tick(); f_pop = 1'b1;
        tick(); f_pop = 1'b0;
        neg();
        chk("fifo_empty", {31'b0, f_empty}, 32'h1);

        // Streaming fetch from reset
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1;
        n0 = nreq; base = log_pc.size();
        repeat (16) tick();
        neg();
        chk("stream_count", {31'b0, (log_pc.size() - base) >= 3}, 32'h1);
        chk("stream_pc0", lp(base), 32'h0);
        chk("stream_pc1", lp(base + 1), 32'h4);
        chk("stream_pc2", lp(base + 2), 32'h8);
        chk("stream_data0", ld(base), 32'hA5A5A5A5);
        chk("stream_data2", ld(base + 2), 32'hA5A5A5AD);
        chk("pc_enable_pulses", pe_bad, 32'h0);
        chk("pc_vs_accepts", pc, 32'(4 * (nreq - n0)));

        // Decode stalled: credit runs out after DEPTH requests
        do_reset();
        req_ready = 1'b1;
        n0 = nreq;
        repeat (10) tick();
        neg();
        chk("stall_requests", nreq - n0, 32'h2);
        chk("stall_state", 32'(dut.state), 32'(ST_STALL));
        chk("stall_req_valid", {31'b0, req_valid}, 32'h0);
        chk("stall_inst_valid", {31'b0, inst_valid}, 32'h1);
        chk("stall_head_pc", inst_pc, 32'h0);
        chk("stall_head_data", inst, 32'hA5A5A5A5);
        tick(); inst_ready = 1'b1;
        neg();
        chk("stall_pop_pc", inst_pc, 32'h0);
        tick(); inst_ready = 1'b0;
        neg();
        chk("stall_next_pc", inst_pc, 32'h4);
        chk("stall_next_data", inst, 32'hA5A5A5A1);
        chk("stall_refetch_valid", {31'b0, req_valid}, 32'h1);
        chk("stall_refetch_addr", req_addr, 32'h8);

        // Redirect with two requests outstanding
        do_reset();
        req_ready = 1'b1; mem_hold = 1'b1;
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        neg();
        chk("redir_next_pc", next_pc, 32'h100);
        chk("redir_pc_enable", {31'b0, pc_en}, 32'h1);
        chk("redir_no_req", {31'b0, req_valid}, 32'h0);
        tick(); redirect = 1'b0; mem_hold = 1'b0; inst_ready = 1'b1;
        base = log_pc.size();
        neg();
        chk("redir_pc_reg", pc, 32'h100);
        chk("redir_inst_valid_p1", {31'b0, inst_valid}, 32'h0);
        repeat (14) tick();
        neg();
        chk("redir_first_pc", lp(base), 32'h100);
        chk("redir_first_data", ld(base), 32'hA5A5A4A5);
        chk("redir_second_pc", lp(base + 1), 32'h104);

        // Response with nothing outstanding, then PC wrap
        do_reset();
        spurious = 1'b1;
        tick(); spurious = 1'b0;
        tick();
        neg();
        chk("spurious_c2", {31'b0, inst_valid}, 32'h0);
        tick();
        neg();
        chk("spurious_c3", {31'b0, inst_valid}, 32'h0);
        chk("no_accept_pc_enable", {31'b0, pc_en}, 32'h0);
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
        neg();
        chk("wrap_redirect_pc", next_pc, 32'hFFFFFFFC);
        tick(); redirect = 1'b0;
        neg();
        chk("wrap_req_addr", req_addr, 32'hFFFFFFFC);
        chk("wrap_wait_pc_enable", {31'b0, pc_en}, 32'h0);
        tick(); req_ready = 1'b1;
        neg();
        chk("wrap_accept_pc_enable", {31'b0, pc_en}, 32'h1);
        chk("wrap_next_pc", next_pc, 32'h0);
        tick(); req_ready = 1'b0;
        neg();
        chk("wrap_pc_reg", pc, 32'h0);

`ifdef JPC_IFETCH_FAULT_EN
        // Fetch fault on 0x20, then recovery by redirect
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1; err_en = 1'b1; err_addr = 32'h20;
        redirect = 1'b1; redirect_pc = 32'h18;
        base = log_pc.size();
        tick(); redirect = 1'b0;
        repeat (15) tick();
        neg();
        chk("fault_flag", {31'b0, fault}, 32'h1);
        chk("fault_pc", fault_pc, 32'h20);
        chk("fault_state", 32'(dut.state), 32'(ST_HALT));
        chk("fault_no_req", {31'b0, req_valid}, 32'h0);
        chk("fault_delivered", log_pc.size() - base, 32'h2);
        chk("fault_last_pc", lp(base + 1), 32'h1C);
        n1 = nreq;
        repeat (5) tick();
        neg();
        chk("fault_halted", nreq - n1, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h40;
        base = log_pc.size();
        tick(); redirect = 1'b0;
        neg();
        chk("fault_cleared", {31'b0, fault}, 32'h0);
        repeat (10) tick();
        neg();
        chk("fault_resume_pc", lp(base), 32'h40);
        chk("fault_resume_data", ld(base), 32'hA5A5A5E5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jpc_ifetch.md
JPC_IFETCH -- requirements
Module: jpc_ifetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2: instruction buffer entries and maximum outstanding memory requests (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port pc_I, input, 32: current PC from the PC register.
REQ-005 SHALL have port next_pc_O, output, 32: next PC value presented to the PC register.
REQ-006 SHALL have port pc_enable_O, output, 1: PC register update strobe.
REQ-007 SHALL have ports imem_req_valid_O (output, 1), imem_req_ready_I (input, 1), imem_req_addr_O (output, 32): fetch request channel.
REQ-008 SHALL have ports imem_rsp_valid_I (input, 1), imem_rsp_data_I (input, 32): in-order fetch response channel, no backpressure.
REQ-009 SHALL have ports inst_valid_O (output, 1), inst_ready_I (input, 1), inst_O (output, 32), inst_pc_O (output, 32): decode-side instruction channel.
REQ-010 SHALL have ports redirect_I (input, 1), redirect_pc_I (input, 32): branch/jump redirect from execute.

Function
REQ-011 SHALL assert imem_req_valid_O with imem_req_addr_O = pc_I when (outstanding + buffered) < DEPTH, redirect_I low, and state is FETCH.
REQ-012 SHALL, on request handshake (valid and ready), drive pc_enable_O = 1, next_pc_O = pc_I + 4 (mod 2^32, wraps 0xFFFFFFFC -> 0), and record pc_I in the in-flight address queue.
REQ-013 SHALL, when redirect_I = 1, drive pc_enable_O = 1 and next_pc_O = redirect_pc_I in that cycle; redirect has priority and no request is issued that cycle.
REQ-014 SHALL, on redirect, flush the instruction buffer and mark all outstanding requests stale; stale responses are counted down and discarded, never written to the buffer.
REQ-015 SHALL write each non-stale response (imem_rsp_data_I, queued address) into the buffer in the cycle after imem_rsp_valid_I.
REQ-016 SHALL present the buffer head on inst_O/inst_pc_O with inst_valid_O when non-empty; an entry pops on inst_valid_O and inst_ready_I.
REQ-017 SHALL allow simultaneous push and pop when full; credit accounting updates both in the same cycle.
REQ-018 SHALL drive inst_valid_O = 0 in the redirect cycle and the following cycle, and SHALL ignore inst_ready_I in those cycles.
REQ-019 SHALL implement states FETCH (issuing), STALL (credit exhausted; return to FETCH when credit frees), HALT (REQ-027); redirect in any state moves to FETCH.
REQ-020 SHALL keep pc_enable_O = 0 in all cycles other than those in REQ-012/REQ-013.
REQ-021 SHALL never exceed DEPTH outstanding requests; imem_rsp_valid_I with zero outstanding is ignored.

Reset
REQ-022 SHALL, while rst is high, force state FETCH, buffer empty, outstanding = 0, stale = 0.
REQ-023 SHALL drive reset values: pc_enable_O = 0, next_pc_O = 0, imem_req_valid_O = 0, inst_valid_O = 0, inst_O = 0, inst_pc_O = 0.
REQ-024 SHALL issue the first request no earlier than the first rising edge after rst deasserts.
REQ-025 SHALL discard any response arriving in the cycle rst deasserts.

Configuration
REQ-026 SHALL compile the fetch-fault feature only when JPC_IFETCH_FAULT_EN is defined.
REQ-027 SHALL, with JPC_IFETCH_FAULT_EN, add input imem_rsp_err_I and outputs fault_O, fault_pc_O [31:0]; an erroring non-stale response enters HALT, drops the instruction, sets fault_O = 1 and fault_pc_O = its address until redirect.
REQ-028 SHALL, without JPC_IFETCH_FAULT_EN, have none of those ports and no HALT state.

Structure
REQ-029 SHALL take XLEN = 32, INSN_BYTES = 4 and the state enum from shared package jpc_pkg.
REQ-030 SHALL place the instruction/address buffer in sub-module jpc_ifetch_fifo (parameter DEPTH, data and address fields, push/pop/flush, full/empty).

Verification
REQ-031 Reset then ready = 1, memory returning addr^0xA5A5A5A5 at 1-cycle latency, inst_ready_I = 1 -> inst_pc_O 0x0, 0x4, 0x8 in order, pc_enable_O pulsing once per accept.
REQ-032 inst_ready_I = 0 for 10 cycles, DEPTH = 2 -> exactly 2 requests issued, state STALL, no buffer overwrite.
REQ-033 redirect_I with redirect_pc_I = 0x100 while 2 requests are outstanding -> next_pc_O = 0x100, both stale responses dropped, first delivered inst_pc_O = 0x100.
REQ-034 pc_I = 0xFFFFFFFC, request accepted -> next_pc_O = 0x00000000.
REQ-035 Buffer full with push and pop in the same cycle -> occupancy unchanged, order preserved.
REQ-036 With JPC_IFETCH_FAULT_EN, err on address 0x20 -> fault_O = 1, fault_pc_O = 0x20, no further requests; redirect to 0x40 clears fault_O and resumes.
